// File: rtl/dcache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_defs
// Brief    : Shared bus/MSHR encodings, default geometry and address slicers.
// Revision : 1.0
// ============================================================================
package dcache_defs;

    localparam int DC_N_LINES   = 32;
    localparam int DC_IDX_BITS  = 5;
    localparam int DC_N_MSHR    = 4;
    localparam int DC_MSHR_BITS = 2;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        MSHR_FREE      = 2'd0,
        MSHR_WAIT_SEND = 2'd1,
        MSHR_WAIT_DATA = 2'd2,
        MSHR_DONE      = 2'd3
    } mshr_state_e;

endpackage

// Byte address -> direct-mapped index / tag for IB index bits over 8-byte blocks.
`define DC_IDX(a, IB) a[(IB)+2:3]
`define DC_TAG(a, IB) a[63:(IB)+3]

`default_nettype wire

// File: rtl/dcache_mshr.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mshr
// Brief    : Non-blocking load miss table: allocate, send-select, tag match,
//            done-select and cache-fill request.
// Revision : 1.0
// ============================================================================
module dcache_mshr
    import dcache_defs::*;
#(
    parameter int N_MSHR    = DC_N_MSHR,
    parameter int MSHR_BITS = DC_MSHR_BITS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alloc_i,
    input  logic [60:0] alloc_blk_i,
    input  logic [6:0]  alloc_pr_i,
    input  logic [4:0]  alloc_ar_i,
    input  logic        port_free_i,
    input  logic [3:0]  mem_resp_i,
    input  logic [3:0]  mem_tag_i,
    input  logic [63:0] mem_data_i,
    input  logic        st_acc_i,
    input  logic [60:0] st_blk_i,
    input  logic        free_i,
    output logic        any_free_o,
    output logic        send_valid_o,
    output logic [60:0] send_blk_o,
    output logic        done_valid_o,
    output logic [6:0]  done_pr_o,
    output logic [4:0]  done_ar_o,
    output logic [63:0] done_data_o,
    output logic        fill_valid_o,
    output logic [60:0] fill_blk_o,
    output logic [63:0] fill_data_o
);

    mshr_state_e        state_q [N_MSHR];
    mshr_state_e        state_d [N_MSHR];
    logic [60:0]        blk_q   [N_MSHR];
    logic [6:0]         pr_q    [N_MSHR];
    logic [4:0]         ar_q    [N_MSHR];
    logic [3:0]         mtag_q  [N_MSHR];
    logic [63:0]        data_q  [N_MSHR];
    logic [N_MSHR-1:0]  nofill_q;

    logic [N_MSHR-1:0]  w_free_v, w_send_v, w_done_v, w_cap_v, w_nf_set;
    logic [N_MSHR-1:0]  w_alloc_oh, w_send_oh, w_done_oh, w_cap_oh;
    logic [MSHR_BITS-1:0] w_send_idx, w_done_idx, w_cap_idx;
    logic               w_send_go;

    always_comb begin
        w_free_v = '0;
        w_send_v = '0;
        w_done_v = '0;
        w_cap_v  = '0;
        w_nf_set = '0;
        for (int i = 0; i < N_MSHR; i++) begin
            w_free_v[i] = (state_q[i] == MSHR_FREE);
            w_send_v[i] = (state_q[i] == MSHR_WAIT_SEND);
            w_done_v[i] = (state_q[i] == MSHR_DONE);
            w_cap_v[i]  = (state_q[i] == MSHR_WAIT_DATA) && (mem_tag_i != 4'd0)
                          && (mem_tag_i == mtag_q[i]);
            // A store to an in-flight block makes the returning data stale for the cache.
            w_nf_set[i] = st_acc_i && (blk_q[i] == st_blk_i)
                          && ((state_q[i] == MSHR_WAIT_SEND) || (state_q[i] == MSHR_WAIT_DATA));
        end
    end

    assign w_alloc_oh = w_free_v & (~w_free_v + N_MSHR'(1));
    assign w_send_oh  = w_send_v & (~w_send_v + N_MSHR'(1));
    assign w_done_oh  = w_done_v & (~w_done_v + N_MSHR'(1));
    assign w_cap_oh   = w_cap_v  & (~w_cap_v  + N_MSHR'(1));

    always_comb begin
        w_send_idx = '0;
        w_done_idx = '0;
        w_cap_idx  = '0;
        for (int i = 0; i < N_MSHR; i++) begin
            if (w_send_oh[i]) w_send_idx = MSHR_BITS'(i);
            if (w_done_oh[i]) w_done_idx = MSHR_BITS'(i);
            if (w_cap_oh[i])  w_cap_idx  = MSHR_BITS'(i);
        end
    end

    assign w_send_go = port_free_i && (|w_send_v) && (mem_resp_i != 4'd0);

    always_comb begin
        for (int i = 0; i < N_MSHR; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                MSHR_FREE:      if (alloc_i && w_alloc_oh[i])  state_d[i] = MSHR_WAIT_SEND;
                MSHR_WAIT_SEND: if (w_send_go && w_send_oh[i]) state_d[i] = MSHR_WAIT_DATA;
                MSHR_WAIT_DATA: if (w_cap_v[i])                state_d[i] = MSHR_DONE;
                MSHR_DONE:      if (free_i && w_done_oh[i])    state_d[i] = MSHR_FREE;
                default:                                       state_d[i] = MSHR_FREE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            nofill_q <= '0;
            for (int i = 0; i < N_MSHR; i++) begin
                state_q[i] <= MSHR_FREE;
                blk_q[i]   <= '0;
                pr_q[i]    <= '0;
                ar_q[i]    <= '0;
                mtag_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_MSHR; i++) begin
                state_q[i] <= state_d[i];
                if (alloc_i && w_alloc_oh[i]) begin
                    blk_q[i]    <= alloc_blk_i;
                    pr_q[i]     <= alloc_pr_i;
                    ar_q[i]     <= alloc_ar_i;
                    nofill_q[i] <= 1'b0;
                end else if (w_nf_set[i]) begin
                    nofill_q[i] <= 1'b1;
                end
                if (w_send_go && w_send_oh[i]) mtag_q[i] <= mem_resp_i;
                if (w_cap_v[i])                data_q[i] <= mem_data_i;
            end
        end
    end

    assign any_free_o   = |w_free_v;
    assign send_valid_o = |w_send_v;
    assign send_blk_o   = blk_q[w_send_idx];
    assign done_valid_o = |w_done_v;
    assign done_pr_o    = done_valid_o ? pr_q[w_done_idx]   : '0;
    assign done_ar_o    = done_valid_o ? ar_q[w_done_idx]   : '0;
    assign done_data_o  = done_valid_o ? data_q[w_done_idx] : '0;
    assign fill_valid_o = (|w_cap_v) && !nofill_q[w_cap_idx] && !w_nf_set[w_cap_idx];
    assign fill_blk_o   = blk_q[w_cap_idx];
    assign fill_data_o  = mem_data_i;

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped write-through data cache with 1-entry store buffer
//            and non-blocking miss table, feeding the CDB/PRF write port.
// Revision : 1.0
// ============================================================================
module dcache_ctrl
    import dcache_defs::*;
#(
    parameter int N_LINES   = DC_N_LINES,
    parameter int IDX_BITS  = DC_IDX_BITS,
    parameter int N_MSHR    = DC_N_MSHR,
    parameter int MSHR_BITS = DC_MSHR_BITS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsq_rd_mem,
    input  logic [63:0] lsq_addr,
    input  logic [6:0]  lsq_pr_idx,
    input  logic [4:0]  lsq_ar_idx,
    input  logic        lsq_st_valid,
    input  logic [63:0] lsq_st_addr,
    input  logic [63:0] lsq_st_value,
    output logic        Dcache_avail,
    output logic        Dcache_st_ready,
    input  logic        cdb_ready,
    output logic        cdb_complete,
    output logic [6:0]  cdb_prf_pr_idx,
    output logic [4:0]  cdb_ar_idx,
    output logic        prf_pr_wr_enable,
    output logic [63:0] prf_pr_value,
    output logic [1:0]  proc2Mem_command,
    output logic [63:0] proc2Mem_addr,
    output logic [63:0] proc2Mem_data,
    input  logic [3:0]  Mem2proc_response,
    input  logic [63:0] Mem2proc_data,
    input  logic [3:0]  Mem2proc_tag
);

    localparam int TAG_W = 64 - IDX_BITS - 3;

    logic [N_LINES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [N_LINES];
    logic [63:0]        line_q [N_LINES];

    logic               sb_valid_q;
    logic [60:0]        sb_blk_q;
    logic [63:0]        sb_data_q;

    logic               hit_valid_q;
    logic [6:0]         hit_pr_q;
    logic [4:0]         hit_ar_q;
    logic [63:0]        hit_val_q;

    logic [IDX_BITS-1:0] w_ld_idx, w_st_idx, w_fill_idx;
    logic [TAG_W-1:0]    w_ld_tag, w_st_tag, w_fill_tag;
    logic [63:0]         w_fill_addr, w_fill_data, w_done_data;
    logic [60:0]         w_fill_blk, w_send_blk;
    logic [6:0]          w_done_pr;
    logic [4:0]          w_done_ar;
    logic w_any_free, w_send_valid, w_done_valid, w_fill_valid;
    logic w_sb_fwd, w_cache_hit, w_ld_acc, w_ld_hit, w_ld_miss;
    logic w_sb_drain, w_st_acc, w_st_upd, w_hit_clr;
    logic w_unused;

    assign w_ld_idx    = `DC_IDX(lsq_addr, IDX_BITS);
    assign w_ld_tag    = `DC_TAG(lsq_addr, IDX_BITS);
    assign w_st_idx    = `DC_IDX(lsq_st_addr, IDX_BITS);
    assign w_st_tag    = `DC_TAG(lsq_st_addr, IDX_BITS);
    assign w_fill_addr = {w_fill_blk, 3'b000};
    assign w_fill_idx  = `DC_IDX(w_fill_addr, IDX_BITS);
    assign w_fill_tag  = `DC_TAG(w_fill_addr, IDX_BITS);
    assign w_unused    = ^{lsq_addr[2:0], lsq_st_addr[2:0], w_fill_addr[2:0]};

    assign Dcache_avail    = !hit_valid_q && w_any_free;
    assign w_sb_drain      = sb_valid_q && (Mem2proc_response != 4'd0);
    assign Dcache_st_ready = !sb_valid_q || w_sb_drain;
    assign w_st_acc        = lsq_st_valid && Dcache_st_ready;
    assign w_st_upd        = w_st_acc && valid_q[w_st_idx] && (tag_q[w_st_idx] == w_st_tag);

    assign w_ld_acc    = lsq_rd_mem && Dcache_avail;
    assign w_sb_fwd    = sb_valid_q && (sb_blk_q == lsq_addr[63:3]);
    assign w_cache_hit = valid_q[w_ld_idx] && (tag_q[w_ld_idx] == w_ld_tag);
    assign w_ld_hit    = w_ld_acc && (w_sb_fwd || w_cache_hit);
    assign w_ld_miss   = w_ld_acc && !(w_sb_fwd || w_cache_hit);
    assign w_hit_clr   = cdb_ready && !w_done_valid && hit_valid_q;

    dcache_mshr #(
        .N_MSHR    (N_MSHR),
        .MSHR_BITS (MSHR_BITS)
    ) u_mshr (
        .clock        (clock),
        .reset        (reset),
        .alloc_i      (w_ld_miss),
        .alloc_blk_i  (lsq_addr[63:3]),
        .alloc_pr_i   (lsq_pr_idx),
        .alloc_ar_i   (lsq_ar_idx),
        .port_free_i  (!sb_valid_q),
        .mem_resp_i   (Mem2proc_response),
        .mem_tag_i    (Mem2proc_tag),
        .mem_data_i   (Mem2proc_data),
        .st_acc_i     (w_st_acc),
        .st_blk_i     (lsq_st_addr[63:3]),
        .free_i       (cdb_ready && w_done_valid),
        .any_free_o   (w_any_free),
        .send_valid_o (w_send_valid),
        .send_blk_o   (w_send_blk),
        .done_valid_o (w_done_valid),
        .done_pr_o    (w_done_pr),
        .done_ar_o    (w_done_ar),
        .done_data_o  (w_done_data),
        .fill_valid_o (w_fill_valid),
        .fill_blk_o   (w_fill_blk),
        .fill_data_o  (w_fill_data)
    );

    // Fill is ordered after the store update so a replacing fill owns the line.
    always_ff @(posedge clock) begin
        if (w_st_upd) line_q[w_st_idx] <= lsq_st_value;
        if (w_fill_valid) begin
            tag_q[w_fill_idx]  <= w_fill_tag;
            line_q[w_fill_idx] <= w_fill_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q     <= '0;
            sb_valid_q  <= 1'b0;
            sb_blk_q    <= '0;
            sb_data_q   <= '0;
            hit_valid_q <= 1'b0;
            hit_pr_q    <= '0;
            hit_ar_q    <= '0;
            hit_val_q   <= '0;
        end else begin
            if (w_fill_valid) valid_q[w_fill_idx] <= 1'b1;
            if (w_st_acc) begin
                sb_valid_q <= 1'b1;
                sb_blk_q   <= lsq_st_addr[63:3];
                sb_data_q  <= lsq_st_value;
            end else if (w_sb_drain) begin
                sb_valid_q <= 1'b0;
            end
            if (w_ld_hit) begin
                hit_valid_q <= 1'b1;
                hit_pr_q    <= lsq_pr_idx;
                hit_ar_q    <= lsq_ar_idx;
                hit_val_q   <= w_sb_fwd ? sb_data_q : line_q[w_ld_idx];
            end else if (w_hit_clr) begin
                hit_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        proc2Mem_command = BUS_NONE;
        proc2Mem_addr    = '0;
        proc2Mem_data    = '0;
        if (sb_valid_q) begin
            proc2Mem_command = BUS_STORE;
            proc2Mem_addr    = {sb_blk_q, 3'b000};
            proc2Mem_data    = sb_data_q;
        end else if (w_send_valid) begin
            proc2Mem_command = BUS_LOAD;
            proc2Mem_addr    = {w_send_blk, 3'b000};
        end
    end

    always_comb begin
        cdb_complete   = w_done_valid || hit_valid_q;
        cdb_prf_pr_idx = '0;
        cdb_ar_idx     = '0;
        prf_pr_value   = '0;
        if (w_done_valid) begin
            cdb_prf_pr_idx = w_done_pr;
            cdb_ar_idx     = w_done_ar;
            prf_pr_value   = w_done_data;
        end else if (hit_valid_q) begin
            cdb_prf_pr_idx = hit_pr_q;
            cdb_ar_idx     = hit_ar_q;
            prf_pr_value   = hit_val_q;
        end
    end

    assign prf_pr_wr_enable = cdb_complete;

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Directed self-checking bench for dcache_ctrl.
// Revision : 1.0
// ============================================================================
module tb_dcache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        lsq_rd_mem;
    logic [63:0] lsq_addr;
    logic [6:0]  lsq_pr_idx;
    logic [4:0]  lsq_ar_idx;
    logic        lsq_st_valid;
    logic [63:0] lsq_st_addr;
    logic [63:0] lsq_st_value;
    logic        Dcache_avail;
    logic        Dcache_st_ready;
    logic        cdb_ready;
    logic        cdb_complete;
    logic [6:0]  cdb_prf_pr_idx;
    logic [4:0]  cdb_ar_idx;
    logic        prf_pr_wr_enable;
    logic [63:0] prf_pr_value;
    logic [1:0]  proc2Mem_command;
    logic [63:0] proc2Mem_addr;
    logic [63:0] proc2Mem_data;
    logic [3:0]  Mem2proc_response;
    logic [63:0] Mem2proc_data;
    logic [3:0]  Mem2proc_tag;

    int total;
    int bad;

    dcache_ctrl u_dut (
        .clock             (clock),
        .reset             (reset),
        .lsq_rd_mem        (lsq_rd_mem),
        .lsq_addr          (lsq_addr),
        .lsq_pr_idx        (lsq_pr_idx),
        .lsq_ar_idx        (lsq_ar_idx),
        .lsq_st_valid      (lsq_st_valid),
        .lsq_st_addr       (lsq_st_addr),
        .lsq_st_value      (lsq_st_value),
        .Dcache_avail      (Dcache_avail),
        .Dcache_st_ready   (Dcache_st_ready),
        .cdb_ready         (cdb_ready),
        .cdb_complete      (cdb_complete),
        .cdb_prf_pr_idx    (cdb_prf_pr_idx),
        .cdb_ar_idx        (cdb_ar_idx),
        .prf_pr_wr_enable  (prf_pr_wr_enable),
        .prf_pr_value      (prf_pr_value),
        .proc2Mem_command  (proc2Mem_command),
        .proc2Mem_addr     (proc2Mem_addr),
        .proc2Mem_data     (proc2Mem_data),
        .Mem2proc_response (Mem2proc_response),
        .Mem2proc_data     (Mem2proc_data),
        .Mem2proc_tag      (Mem2proc_tag)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        lsq_rd_mem        = 1'b0;
        lsq_addr          = '0;
        lsq_pr_idx        = '0;
        lsq_ar_idx        = '0;
        lsq_st_valid      = 1'b0;
        lsq_st_addr       = '0;
        lsq_st_value      = '0;
        cdb_ready         = 1'b0;
        Mem2proc_response = '0;
        Mem2proc_data     = '0;
        Mem2proc_tag      = '0;
    endtask

    task automatic ld(input logic [63:0] a, input logic [6:0] pr, input logic [4:0] ar);
        lsq_rd_mem = 1'b1;
        lsq_addr   = a;
        lsq_pr_idx = pr;
        lsq_ar_idx = ar;
    endtask

    task automatic st(input logic [63:0] a, input logic [63:0] v);
        lsq_st_valid = 1'b1;
        lsq_st_addr  = a;
        lsq_st_value = v;
    endtask

    task automatic check_result(input string tag, input logic [6:0] pr, input logic [63:0] v);
        check_val({tag, "_cmp"}, 64'(cdb_complete), 64'd1);
        check_val({tag, "_pr"},  64'(cdb_prf_pr_idx), 64'(pr));
        check_val({tag, "_val"}, prf_pr_value, v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idle();
        step();
        step();
        reset = 1'b1;
        #1;
        check_val("rst_avail", 64'(Dcache_avail), 64'd1);
        check_val("rst_st_ready", 64'(Dcache_st_ready), 64'd1);
        check_val("rst_cmp", 64'(cdb_complete), 64'd0);
        check_val("rst_wren", 64'(prf_pr_wr_enable), 64'd0);
        check_val("rst_cmd", 64'(proc2Mem_command), 64'd0);
        check_val("rst_val", prf_pr_value, 64'd0);
        check_val("rst_addr", proc2Mem_addr, 64'd0);

        // Miss on 0x100, then a hit on the filled line
        idle(); ld(64'h100, 7'd9, 5'd3); #1;
        check_val("m_avail", 64'(Dcache_avail), 64'd1);
        step();
        idle(); Mem2proc_response = 4'd3; #1;
        check_val("m_cmd", 64'(proc2Mem_command), 64'd1);
        check_val("m_addr", proc2Mem_addr, 64'h100);
        step();
        idle(); Mem2proc_tag = 4'd3; Mem2proc_data = 64'hDEAD; #1;
        check_val("m_cmd_idle", 64'(proc2Mem_command), 64'd0);
        check_val("m_cmp_early", 64'(cdb_complete), 64'd0);
        step();
        idle(); cdb_ready = 1'b1; #1;
        check_result("m_res", 7'd9, 64'hDEAD);
        check_val("m_ar", 64'(cdb_ar_idx), 64'd3);
        check_val("m_wren", 64'(prf_pr_wr_enable), 64'd1);
        step();
        idle(); ld(64'h100, 7'd10, 5'd4); #1;
        check_val("h_cmp_clr", 64'(cdb_complete), 64'd0);
        check_val("h_avail", 64'(Dcache_avail), 64'd1);
        step();
        idle(); cdb_ready = 1'b1; #1;
        check_result("h_res", 7'd10, 64'hDEAD);
        check_val("h_cmd", 64'(proc2Mem_command), 64'd0);
        step();

        // Store buffer retry and forwarding
        idle(); st(64'h200, 64'h55); #1;
        check_val("s_ready0", 64'(Dcache_st_ready), 64'd1);
        step();
        idle(); #1;
        check_val("s_cmd", 64'(proc2Mem_command), 64'd2);
        check_val("s_addr", proc2Mem_addr, 64'h200);
        check_val("s_data", proc2Mem_data, 64'h55);
        check_val("s_ready1", 64'(Dcache_st_ready), 64'd0);
        step();
        idle(); ld(64'h200, 7'd11, 5'd5); #1;
        check_val("s_retry", 64'(proc2Mem_command), 64'd2);
        check_val("s_ready2", 64'(Dcache_st_ready), 64'd0);
        step();
        idle(); cdb_ready = 1'b1; Mem2proc_response = 4'd5; #1;
        check_result("f_res", 7'd11, 64'h55);
        check_val("s_drain_ready", 64'(Dcache_st_ready), 64'd1);
        step();
        idle(); #1;
        check_val("s_cmd_done", 64'(proc2Mem_command), 64'd0);
        check_val("s_cmp_clr", 64'(cdb_complete), 64'd0);

        // Fill all four MSHRs with sends held back
        for (int i = 0; i < 4; i++) begin
            idle(); ld(64'h400 + 64'(8 * i), 7'(20 + i), 5'(i)); #1;
            check_val("full_avail_pre", 64'(Dcache_avail), 64'd1);
            step();
        end
        idle(); #1;
        check_val("full_avail", 64'(Dcache_avail), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(); Mem2proc_response = 4'(i + 1); #1;
            check_val("full_cmd", 64'(proc2Mem_command), 64'd1);
            check_val("full_addr", proc2Mem_addr, 64'h400 + 64'(8 * i));
            step();
        end
        idle(); Mem2proc_tag = 4'd2; Mem2proc_data = 64'hBEEF; #1;
        check_val("full_cmd_idle", 64'(proc2Mem_command), 64'd0);
        check_val("full_avail2", 64'(Dcache_avail), 64'd0);
        step();
        idle(); #1;
        check_result("full_res", 7'd21, 64'hBEEF);
        check_val("full_avail3", 64'(Dcache_avail), 64'd0);
        cdb_ready = 1'b1;
        step();
        idle(); #1;
        check_val("full_avail_free", 64'(Dcache_avail), 64'd1);
        check_val("full_cmp_clr", 64'(cdb_complete), 64'd0);

        // Back-pressure with a DONE entry and a pending hit
        Mem2proc_tag = 4'd1; Mem2proc_data = 64'h111; ld(64'h100, 7'd30, 5'd6);
        step();
        for (int i = 0; i < 3; i++) begin
            idle(); #1;
            check_result("bp_hold", 7'd20, 64'h111);
            check_val("bp_avail", 64'(Dcache_avail), 64'd0);
            step();
        end
        idle(); cdb_ready = 1'b1; #1;
        check_result("bp_mshr", 7'd20, 64'h111);
        step();
        idle(); cdb_ready = 1'b1; #1;
        check_result("bp_hit", 7'd30, 64'hDEAD);
        step();
        idle(); Mem2proc_tag = 4'd3; Mem2proc_data = 64'h333; #1;
        check_val("bp_cmp_clr", 64'(cdb_complete), 64'd0);
        step();
        idle(); Mem2proc_tag = 4'd4; Mem2proc_data = 64'h444; cdb_ready = 1'b1; #1;
        check_result("dr_e2", 7'd22, 64'h333);
        step();
        idle(); cdb_ready = 1'b1; #1;
        check_result("dr_e3", 7'd23, 64'h444);
        step();

        // Store to an in-flight miss suppresses the fill
        idle(); ld(64'h300, 7'd40, 5'd7); #1;
        check_val("nf_avail", 64'(Dcache_avail), 64'd1);
        step();
        idle(); Mem2proc_response = 4'd6; #1;
        check_val("nf_cmd", 64'(proc2Mem_command), 64'd1);
        check_val("nf_addr", proc2Mem_addr, 64'h300);
        step();
        idle(); st(64'h300, 64'd7); #1;
        check_val("nf_st_ready", 64'(Dcache_st_ready), 64'd1);
        step();
        idle(); Mem2proc_response = 4'd7; Mem2proc_tag = 4'd6; Mem2proc_data = 64'hAAAA; #1;
        check_val("nf_st_cmd", 64'(proc2Mem_command), 64'd2);
        check_val("nf_st_data", proc2Mem_data, 64'd7);
        step();
        idle(); cdb_ready = 1'b1; #1;
        check_result("nf_res", 7'd40, 64'hAAAA);
        step();
        idle(); ld(64'h300, 7'd41, 5'd8); #1;
        check_val("nf_avail2", 64'(Dcache_avail), 64'd1);
        step();
        idle(); Mem2proc_response = 4'd8; #1;
        check_val("nf_refetch_cmp", 64'(cdb_complete), 64'd0);
        check_val("nf_refetch_cmd", 64'(proc2Mem_command), 64'd1);
        check_val("nf_refetch_addr", proc2Mem_addr, 64'h300);
        step();
        idle(); Mem2proc_tag = 4'd8; Mem2proc_data = 64'd7;
        step();
        idle(); cdb_ready = 1'b1; #1;
        check_result("nf_res2", 7'd41, 64'd7);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
